// File: rtl/bcd_scan_display.sv
// Sequential double-dabble binary-to-BCD converter with a multiplexed,
// common-anode seven-segment scan driver (leading-zero blanking, overflow dash).
module bcd_scan_display #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int SN  = (WIDTH + 3) / 3;
  localparam int NN  = (SN > DIGITS) ? SN : DIGITS;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]  CNT_INIT  = CW'(WIDTH);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]     SEG_DASH  = 7'b0111111;
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4*NN-1:0]     scr_q, scr_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [SCW-1:0]      scan_q, scan_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  function automatic logic [4*NN-1:0] add3(input logic [4*NN-1:0] s);
    logic [4*NN-1:0] r;
    r = s;
    for (int i = 0; i < NN; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Any nonzero nibble beyond the displayed digits means the value does not fit.
  function automatic logic upper_nz(input logic [4*NN-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = DIGITS; i < NN; i++) r = r | (|s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scr_d  = scr_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        sh_d  = bin_in;
        scr_d = '0;
        cnt_d = CNT_INIT;
      end
      S_SHIFT: begin
        {scr_d, sh_d} = {add3(scr_q), sh_q} << 1;
        cnt_d         = cnt_q - CW'(1);
      end
      S_DONE: begin
        bcd_d  = scr_q[4*DIGITS-1:0];
        ovf_d  = upper_nz(scr_q);
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scr_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      scr_q  <= scr_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // Scan side: the segment pattern is computed for the next digit index so it
  // lands in the same register stage as the matching anode.
  always_comb begin
    scan_d = scan_q + SCW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    an_d        = '1;
    an_d[idx_d] = 1'b0;
    if (ovf_q)
      seg_d = SEG_DASH;
    else if ((BLANK_LZ != 0) && (idx_d != '0) &&
             ((bcd_q >> (4 * int'(idx_d))) == '0))
      seg_d = SEG_BLANK;
    else
      seg_d = glyph(bcd_q[4*int'(idx_d) +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_q  <= SEG_ZERO;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_out  = bcd_q;
  assign seg_out  = seg_q;
  assign an_out   = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: three instances (4 digits blanked,
// 3 digits for overflow, 4 digits unblanked) with queue-based done monitors.
module tb_bcd_scan_display;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic       st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
  logic [9:0] bin_a = '0, bin_b = '0, bin_c = '0;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [15:0] bcd_a, bcd_c;
  logic [11:0] bcd_b;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_c;
  logic [2:0] an_b;

  bcd_scan_display #(.WIDTH(10), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .bin_in(bin_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a), .bcd_out(bcd_a), .seg_out(seg_a), .an_out(an_a));
  bcd_scan_display #(.WIDTH(10), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .bin_in(bin_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b), .bcd_out(bcd_b), .seg_out(seg_b), .an_out(an_b));
  bcd_scan_display #(.WIDTH(10), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .bin_in(bin_c), .busy(busy_c),
    .done(done_c), .overflow(ovf_c), .bcd_out(bcd_c), .seg_out(seg_c), .an_out(an_c));

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not as expected (t=%0t)", name, $time);
  endtask

  always @(negedge clk) if (done_a) begin
    exp_t e;
    if (qa.size() == 0) flag("a_unexpected_done");
    else begin
      e = qa.pop_front();
      check("a_bcd", 32'(bcd_a), 32'(e.bcd));
      check("a_ovf", 32'(ovf_a), 32'(e.ovf));
      check("a_latency", cyc, e.at);
    end
  end

  always @(negedge clk) if (done_b) begin
    exp_t e;
    if (qb.size() == 0) flag("b_unexpected_done");
    else begin
      e = qb.pop_front();
      check("b_bcd", 32'(bcd_b), 32'(e.bcd));
      check("b_ovf", 32'(ovf_b), 32'(e.ovf));
      check("b_latency", cyc, e.at);
    end
  end

  always @(negedge clk) if (done_c) begin
    exp_t e;
    if (qc.size() == 0) flag("c_unexpected_done");
    else begin
      e = qc.pop_front();
      check("c_bcd", 32'(bcd_c), 32'(e.bcd));
      check("c_ovf", 32'(ovf_c), 32'(e.ovf));
      check("c_latency", cyc, e.at);
    end
  end

  // Called at a negedge: expected result is due 12 counter ticks later
  // (accept edge, then WIDTH shift edges, then the DONE edge).
  task automatic push(input int inst, input logic [15:0] b, input logic o, input int dly);
    exp_t x;
    x.bcd = b;
    x.ovf = o;
    x.at  = cyc + dly;
    case (inst)
      0: qa.push_back(x);
      1: qb.push_back(x);
      default: qc.push_back(x);
    endcase
  endtask

  task automatic go(input int inst, input logic [9:0] v, input logic [15:0] b, input logic o);
    push(inst, b, o, 12);
    case (inst)
      0: begin bin_a = v; st_a = 1'b1; end
      1: begin bin_b = v; st_b = 1'b1; end
      default: begin bin_c = v; st_c = 1'b1; end
    endcase
    @(negedge clk);
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
  endtask

  task automatic wait_q(input string tag);
    int left;
    left = 60;
    while ((qa.size() + qb.size() + qc.size()) != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    if (left == 0) begin
      flag({tag, "_timeout"});
      qa.delete(); qb.delete(); qc.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // One full scan period, sampled every cycle; exp packs {d3,d2,d1,d0}.
  task automatic chk_disp(input int inst, input logic [27:0] exp, input int nd, input string tag);
    for (int s = 0; s < 4 * nd; s++) begin
      logic [6:0] sg;
      logic [3:0] an;
      int k, zeros;
      case (inst)
        0: begin sg = seg_a; an = an_a; end
        1: begin sg = seg_b; an = {1'b1, an_b}; end
        default: begin sg = seg_c; an = an_c; end
      endcase
      zeros = 0;
      k = 0;
      for (int j = 0; j < 4; j++) if (an[j] == 1'b0) begin zeros++; k = j; end
      if (zeros != 1) check($sformatf("%s_an_onehot", tag), 32'(an), 32'hE);
      else check($sformatf("%s_d%0d", tag, k), 32'(sg), 32'(exp[7*k +: 7]));
      @(negedge clk);
    end
  endtask

  initial begin
    int bad;
    logic [3:0] an_exp;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_bcd", 32'(bcd_a), 0);
    check("rst_an", 32'(an_a), 32'hE);
    check("rst_seg", 32'(seg_a), 32'(G0));
    rst_n = 1'b1;

    // Zero value: anode walks every 4 cycles, only digit 0 lit.
    for (int s = 0; s < 16; s++) begin
      an_exp = 4'b1111;
      an_exp[s / 4] = 1'b0;
      check($sformatf("scan_an_s%0d", s), 32'(an_a), 32'(an_exp));
      check($sformatf("scan_seg_s%0d", s), 32'(seg_a), (s < 4) ? 32'(G0) : 32'(BL));
      @(negedge clk);
    end

    // 1023: busy must span exactly 11 cycles.
    push(0, 16'h1023, 1'b0, 12);
    bin_a = 10'd1023; st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      if (busy_a !== 1'b1) bad++;
      @(negedge clk);
    end
    check("a_busy_len", bad, 0);
    check("a_busy_end", 32'(busy_a), 0);
    wait_q("a1023");
    chk_disp(0, {G1, G0, G2, G3}, 4, "disp1023");

    // Overflow on the 3-digit instance.
    go(1, 10'd1000, 16'h0000, 1'b1);
    wait_q("b1000");
    chk_disp(1, {BL, DS, DS, DS}, 3, "disp_ovf");

    // start during SHIFT is ignored, not queued.
    push(0, 16'h0305, 1'b0, 12);
    bin_a = 10'd305; st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    repeat (3) @(negedge clk);
    bin_a = 10'd999; st_a = 1'b1;
    repeat (3) @(negedge clk);
    st_a = 1'b0;
    wait_q("a305");
    repeat (15) @(negedge clk);
    check("a_hold_305", 32'(bcd_a), 32'h0305);
    go(0, 10'd999, 16'h0999, 1'b0);
    wait_q("a999");

    // start held high: a new conversion begins right after DONE.
    push(0, 16'h0012, 1'b0, 12);
    push(0, 16'h0012, 1'b0, 24);
    bin_a = 10'd12; st_a = 1'b1;
    repeat (13) @(negedge clk);
    st_a = 1'b0;
    wait_q("a12held");

    // Asynchronous reset in the middle of SHIFT aborts with no done.
    bin_a = 10'd500; st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_bcd", 32'(bcd_a), 0);
    check("mid_rst_done", 32'(done_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_bcd", 32'(bcd_a), 0);
    go(0, 10'd42, 16'h0042, 1'b0);
    wait_q("a42");
    chk_disp(0, {BL, BL, G4, G2}, 4, "disp42");

    // Leading zeros shown when blanking is disabled.
    go(2, 10'd7, 16'h0007, 1'b0);
    wait_q("c7");
    chk_disp(2, {G0, G0, G0, G7}, 4, "disp7_noblank");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
